id_ex_stage: RTL and testbench

//  Decode->execute pipeline boundary, directly downstream of the register file.
//  - Captures rs/rt read data, sign-extended immediate, register indices and execute control each cycle.
//  - Detects load-use hazards and inserts one bubble, stalling fetch/decode meanwhile.
//  - Honours branch flush and a downstream hold. Keeps a saturating bubble counter.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ctrl_bus_if.sv | 7 +
 rtl/load_use_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the decode/execute boundary: execute control word,
// the NOP control value, the hard-wired zero register and the hazard FSM states.
package cpu_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctrl;
  } ctrl_ex_t;

  localparam ctrl_ex_t   CTRL_NOP = '0;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } hz_state_t;

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and reset bundle for the pipeline stages. Reset is synchronous, active-high.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport dut (input clk, input reset);
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination (rt) is read
// by the instruction currently in decode. Purely combinational.
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_to_reg_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              hz_o
);

  // Writes to the zero register never create a dependency.
  assign hz_o = ex_valid_i && ex_mem_to_reg_i
             && (ex_rt_i != REG_AW'(ZERO_REG))
             && id_valid_i
             && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
// Optional build macro: ID_EX_WB_BYPASS_EN forwards a same-cycle writeback
// into the captured rs/rt operands.
// Handshake: stall_f_o/stall_d_o are combinational and ask fetch/decode to keep
// their current instruction; the instruction in decode is consumed only on a
// cycle where both are low (no flush, hold or hazard). ex_valid_o qualifies
// every ex_* field.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  ctrl_bus_if.dut           ctrl_bus,
  input  logic              id_valid_i,
  input  ctrl_ex_t          id_ctrl_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              ex_valid_o,
  output ctrl_ex_t          ex_ctrl_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output hz_state_t         state_o
);

  logic              ex_valid_q, ex_valid_d;
  ctrl_ex_t          ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d, ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  hz_state_t         state_q, state_d;
  logic [DATA_W-1:0] rs_cap, rt_cap;
  logic              hz;

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .ex_valid_i      (ex_valid_q),
    .ex_mem_to_reg_i (ex_ctrl_q.mem_to_reg),
    .ex_rt_i         (ex_rt_q),
    .id_valid_i      (id_valid_i),
    .id_rs_i         (id_rs_i),
    .id_rt_i         (id_rt_i),
    .hz_o            (hz)
  );

  // Reset and flush override everything; otherwise hold or a hazard freezes fetch/decode.
  assign stall_f_o = !ctrl_bus.reset && !flush_i && (ex_hold_i || hz);
  assign stall_d_o = stall_f_o;

  // Operand selection for capture, optionally bypassing the writeback port.
  always_comb begin
    rs_cap = id_rs_data_i;
    rt_cap = id_rt_data_i;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write_i && (wb_rd_i != REG_AW'(ZERO_REG))) begin
      if (wb_rd_i == id_rs_i) rs_cap = wb_data_i;
      if (wb_rd_i == id_rt_i) rt_cap = wb_data_i;
    end
`endif
  end

`ifndef ID_EX_WB_BYPASS_EN
  // Writeback port has no function without the bypass.
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write_i, wb_rd_i, wb_data_i};
`endif

  // Next-state selection: flush > hold > hazard bubble > normal capture.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    if (flush_i || (!ex_hold_i && hz)) begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = CTRL_NOP;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_rd_d      = '0;
      ex_rs_data_d = '0;
      ex_rt_data_d = '0;
      ex_imm_d     = '0;
      state_d      = RUN;
      if (!flush_i) begin
        state_d = BUBBLE;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!ex_hold_i) begin
      ex_valid_d   = id_valid_i;
      ex_ctrl_d    = id_valid_i ? id_ctrl_i : CTRL_NOP;
      ex_rs_d      = id_rs_i;
      ex_rt_d      = id_rt_i;
      ex_rd_d      = id_rd_i;
      ex_rs_data_d = rs_cap;
      ex_rt_data_d = rt_cap;
      ex_imm_d     = id_imm_i;
      state_d      = RUN;
    end
  end

  // EX register, bubble counter and hazard FSM state.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_NOP;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      cnt_q        <= '0;
      state_q      <= RUN;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
    end
  end

  // After a bubble EX is empty, so a back-to-back hazard cannot arise.
  assert property (@(posedge ctrl_bus.clk) disable iff (ctrl_bus.reset)
                   !(state_q == BUBBLE && hz));

  assign ex_valid_o   = ex_valid_q;
  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_rs_o      = ex_rs_q;
  assign ex_rt_o      = ex_rt_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_rs_data_o = ex_rs_data_q;
  assign ex_rt_data_o = ex_rt_data_q;
  assign ex_imm_o     = ex_imm_q;
  assign bubble_cnt_o = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table-driven capture vectors, hand-written hazard,
// flush, hold, reset and saturation sequences, then randomized traffic checked
// against a cycle-level model of the stage's rules.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

`ifdef ID_EX_WB_BYPASS_EN
  localparam logic [31:0] BYP_RS = 32'h0000_DEAD;
  localparam logic [31:0] BYP_RT = 32'h0000_BEEF;
`else
  localparam logic [31:0] BYP_RS = 32'h0000_0000;
  localparam logic [31:0] BYP_RT = 32'h0000_0005;
`endif

  // ---------------- clock / reset ----------------
  ctrl_bus_if bus ();
  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  logic        id_valid, flush, ex_hold, wb_reg_write;
  ctrl_ex_t    id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, wb_data;
  logic        stall_f, stall_d, ex_valid;
  ctrl_ex_t    ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [CW-1:0] bubble_cnt;
  hz_state_t   state;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .ctrl_bus       (bus),
    .id_valid_i     (id_valid),
    .id_ctrl_i      (id_ctrl),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rd_i        (id_rd),
    .id_rs_data_i   (id_rs_data),
    .id_rt_data_i   (id_rt_data),
    .id_imm_i       (id_imm),
    .flush_i        (flush),
    .ex_hold_i      (ex_hold),
    .wb_reg_write_i (wb_reg_write),
    .wb_rd_i        (wb_rd),
    .wb_data_i      (wb_data),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d),
    .ex_valid_o     (ex_valid),
    .ex_ctrl_o      (ex_ctrl),
    .ex_rs_o        (ex_rs),
    .ex_rt_o        (ex_rt),
    .ex_rd_o        (ex_rd),
    .ex_rs_data_o   (ex_rs_data),
    .ex_rt_data_o   (ex_rt_data),
    .ex_imm_o       (ex_imm),
    .bubble_cnt_o   (bubble_cnt),
    .state_o        (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    ctrl_ex_t    ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
  } ex_t;

  ex_t m;
  int  m_cnt;

  function automatic logic model_hz();
    return m.valid && m.ctrl.mem_to_reg && (m.rt != 5'd0) && id_valid
        && ((m.rt == id_rs) || (m.rt == id_rt));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == idx)) return wb_data;
`endif
    return rf;
  endfunction

  task automatic model_step(input logic hz);
    if (bus.reset) begin
      m     = '0;
      m_cnt = 0;
    end else if (flush) begin
      m = '0;
    end else if (ex_hold) begin
      m = m;
    end else if (hz) begin
      m = '0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m.valid   = id_valid;
      m.ctrl    = id_valid ? id_ctrl : CTRL_NOP;
      m.rs      = id_rs;
      m.rt      = id_rt;
      m.rd      = id_rd;
      m.rs_data = operand(id_rs, id_rs_data);
      m.rt_data = operand(id_rt, id_rt_data);
      m.imm     = id_imm;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    id_valid = 1'b0; id_ctrl = CTRL_NOP;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    flush = 1'b0; ex_hold = 1'b0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0;
  endtask

  task automatic set_id(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rs_d, input logic [31:0] rt_d);
    id_valid = 1'b1; id_ctrl = ctrl_ex_t'(c);
    id_rs = rs; id_rt = rt; id_rd = 5'd8;
    id_rs_data = rs_d; id_rt_data = rt_d; id_imm = 32'h0000_0010;
  endtask

  // One clock: check the combinational stalls, clock, then check EX against the model.
  task automatic cycle();
    logic hz;
    logic exp_stall;
    #1;
    hz        = model_hz();
    exp_stall = !bus.reset && !flush && (ex_hold || hz);
    chk("stall_f", 32'(stall_f), 32'(exp_stall));
    chk("stall_d", 32'(stall_d), 32'(exp_stall));
    @(posedge bus.clk);
    model_step(hz);
    #1;
    chk("m_ex_valid",   32'(ex_valid),   32'(m.valid));
    chk("m_ex_ctrl",    32'(ex_ctrl),    32'(m.ctrl));
    chk("m_ex_rs",      32'(ex_rs),      32'(m.rs));
    chk("m_ex_rt",      32'(ex_rt),      32'(m.rt));
    chk("m_ex_rd",      32'(ex_rd),      32'(m.rd));
    chk("m_ex_rs_data", ex_rs_data,      m.rs_data);
    chk("m_ex_rt_data", ex_rt_data,      m.rt_data);
    chk("m_ex_imm",     ex_imm,          m.imm);
    chk("m_bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    @(negedge bus.clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        e_valid;
    logic [7:0]  e_ctrl;
    logic [31:0] e_rs_data, e_rt_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h82, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFF0, 1'b0, 5'd0, 32'h0,
                1'b1, 8'h82, 32'h11, 32'h22};
    vecs[1] = '{1'b0, 8'h9F, 5'd1, 5'd2, 5'd3, 32'hAA, 32'hBB, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 8'h00, 32'hAA, 32'hBB};
    vecs[2] = '{1'b1, 8'h82, 5'd7, 5'd2, 5'd1, 32'h0, 32'h33, 32'h4, 1'b1, 5'd7, 32'hDEAD,
                1'b1, 8'h82, BYP_RS, 32'h33};
    vecs[3] = '{1'b1, 8'h82, 5'd0, 5'd2, 5'd1, 32'h0, 32'h44, 32'h4, 1'b1, 5'd0, 32'hDEAD,
                1'b1, 8'h82, 32'h0, 32'h44};
    vecs[4] = '{1'b1, 8'h88, 5'd1, 5'd9, 5'd2, 32'h55, 32'h5, 32'h8, 1'b1, 5'd9, 32'hBEEF,
                1'b1, 8'h88, 32'h55, BYP_RT};
    vecs[5] = '{1'b1, 8'h82, 5'd7, 5'd3, 5'd2, 32'h1234, 32'h9, 32'h8, 1'b0, 5'd7, 32'hDEAD,
                1'b1, 8'h82, 32'h1234, 32'h9};
    vecs[6] = '{1'b1, 8'h31, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF,
                1'b0, 5'd0, 32'h0, 1'b1, 8'h31, 32'hFFFF_FFFF, 32'h8000_0000};

    idle();
    m = '0;
    m_cnt = 0;
    bus.reset = 1'b1;
    @(negedge bus.clk);

    // Reset held for two cycles.
    cycle();
    cycle();
    bus.reset = 1'b0;
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    #1;
    chk("reset_stall_f", 32'(stall_f), 32'd0);

    // Table-driven capture vectors.
    for (int i = 0; i < 7; i++) begin
      id_valid = vecs[i].valid; id_ctrl = ctrl_ex_t'(vecs[i].ctrl);
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
      id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data; id_imm = vecs[i].imm;
      wb_reg_write = vecs[i].wbw; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbdata;
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
      chk($sformatf("vec%0d_rs_data", i), ex_rs_data, vecs[i].e_rs_data);
      chk($sformatf("vec%0d_rt_data", i), ex_rt_data, vecs[i].e_rt_data);
      chk($sformatf("vec%0d_imm", i), ex_imm, vecs[i].imm);
    end

    // Load-use: lw $5 in EX, add reading $5 in decode.
    idle();
    set_id(8'hC0, 5'd1, 5'd5, 32'h1, 32'h2);
    cycle();
    set_id(8'h88, 5'd5, 5'd6, 32'h77, 32'h66);
    #1;
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    cycle();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    chk("lu_state_bubble", 32'(state), 32'(BUBBLE));
    #1;
    chk("lu_stall_released", 32'(stall_f), 32'd0);
    cycle();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rs", 32'(ex_rs), 32'd5);
    chk("lu_add_rs_data", ex_rs_data, 32'h77);
    chk("lu_add_ctrl", 32'(ex_ctrl), 32'h88);
    chk("lu_state_run", 32'(state), 32'(RUN));

    // Flush and hazard in the same cycle: flush wins, no count.
    set_id(8'hC0, 5'd1, 5'd5, 32'h1, 32'h2);
    cycle();
    set_id(8'h88, 5'd5, 5'd6, 32'h77, 32'h66);
    flush = 1'b1;
    #1;
    chk("fl_stall_f", 32'(stall_f), 32'd0);
    cycle();
    flush = 1'b0;
    chk("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk("fl_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("fl_ex_rs_data", ex_rs_data, 32'd0);
    chk("fl_bubble_cnt", 32'(bubble_cnt), 32'd1);

    // Hold for three cycles with a pending hazard, then release.
    set_id(8'hC0, 5'd1, 5'd5, 32'hAB, 32'h2);
    cycle();
    set_id(8'h88, 5'd5, 5'd6, 32'h0, 32'h66);
    ex_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_rs_data = 32'(k + 100);
      #1;
      chk("hold_stall_f", 32'(stall_f), 32'd1);
      chk("hold_stall_d", 32'(stall_d), 32'd1);
      cycle();
      chk("hold_ex_valid", 32'(ex_valid), 32'd1);
      chk("hold_ex_rs_data", ex_rs_data, 32'hAB);
      chk("hold_ex_ctrl", 32'(ex_ctrl), 32'hC0);
      chk("hold_bubble_cnt", 32'(bubble_cnt), 32'd1);
    end
    ex_hold = 1'b0;
    cycle();
    chk("hold_release_cnt", 32'(bubble_cnt), 32'd2);
    chk("hold_release_valid", 32'(ex_valid), 32'd0);
    cycle();

    // Reset while a hazard stall is active.
    set_id(8'hC0, 5'd1, 5'd5, 32'h1, 32'h2);
    cycle();
    set_id(8'h88, 5'd5, 5'd6, 32'h77, 32'h66);
    bus.reset = 1'b1;
    #1;
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    cycle();
    bus.reset = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_state", 32'(state), 32'(RUN));
    chk("rst_cnt", 32'(bubble_cnt), 32'd0);
    #1;
    chk("rst_stall_after", 32'(stall_d), 32'd0);

    // Reset while in the bubble state.
    set_id(8'hC0, 5'd1, 5'd5, 32'h1, 32'h2);
    cycle();
    set_id(8'h88, 5'd5, 5'd6, 32'h77, 32'h66);
    cycle();
    chk("rstb_state_bubble", 32'(state), 32'(BUBBLE));
    bus.reset = 1'b1;
    cycle();
    bus.reset = 1'b0;
    chk("rstb_state", 32'(state), 32'(RUN));
    chk("rstb_cnt", 32'(bubble_cnt), 32'd0);

    // Saturation: a self-dependent load alternates capture and bubble.
    set_id(8'hC0, 5'd5, 5'd5, 32'h1, 32'h2);
    repeat (40) cycle();
    chk("sat_cnt", 32'(bubble_cnt), 32'(CNT_MAX));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.reset    = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      ex_hold      = ($urandom_range(0, 5) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_ctrl      = ctrl_ex_t'(8'($urandom_range(0, 255)));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 31));
      id_rs_data   = $urandom();
      id_rt_data   = $urandom();
      id_imm       = $urandom();
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = $urandom();
      cycle();
    end
    bus.reset = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
